// File: rtl/test_mem.sv
// test_mem: 16-entry x 8-bit constant lookup table with a registered,
// enable-gated output. One cycle of latency from address to out.
// Contents live in an explicit case table so they can be re-populated
// without touching the surrounding logic.
module test_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out
);

  // Constant contents. Each word is {address, ~address}, but it is
  // written out entry by entry so the table can change independently.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    case (a)
      4'h0:    w = 8'h0F;
      4'h1:    w = 8'h1E;
      4'h2:    w = 8'h2D;
      4'h3:    w = 8'h3C;
      4'h4:    w = 8'h4B;
      4'h5:    w = 8'h5A;
      4'h6:    w = 8'h69;
      4'h7:    w = 8'h78;
      4'h8:    w = 8'h87;
      4'h9:    w = 8'h96;
      4'hA:    w = 8'hA5;
      4'hB:    w = 8'hB4;
      4'hC:    w = 8'hC3;
      4'hD:    w = 8'hD2;
      4'hE:    w = 8'hE1;
      4'hF:    w = 8'hF0;
      // Unreachable for a resolved address; a known value keeps an
      // unknown address from propagating when it is not being used.
      default: w = 8'h00;
    endcase
    return w;
  endfunction

  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] out_r;

  // Table lookup for the currently presented address.
  always_comb begin
    rd_word_s = rom_word(address);
  end

  // Output register: reset wins over enable; hold when not enabled, so a
  // don't-care address never reaches the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r <= {DATA_W{1'b0}};
    end else if (en) begin
      out_r <= rd_word_s;
    end else begin
      out_r <= out_r;
    end
  end

  assign out = out_r;

endmodule

// File: tb/tb_test_mem.sv
// Self-checking bench for test_mem: directed plan with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_test_mem;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] address;
  logic [7:0] dout;

  int checks;
  int errors;

  // Behavioural model state
  logic [7:0] exp_out;
  logic       exp_valid;

  // Literal table used to pin the model's formula
  logic [7:0] tbl [16];

  test_mem #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .address (address),
    .out     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: reset clears, enable loads {A, ~A}, otherwise hold.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      exp_out   <= 8'h00;
      exp_valid <= 1'b1;
    end else if (en === 1'b1) begin
      exp_out <= {address, ~address};
    end else begin
      exp_out <= exp_out;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %02h want %02h at %0t", name, got, want, $time);
    end
  endtask

  // Compare process: every falling edge once the model is defined.
  always @(negedge clk) begin
    if (exp_valid === 1'b1) begin
      check("model", dout, exp_out);
    end
  end

  // Present inputs, then advance one rising edge and settle.
  task automatic drive(input logic r, input logic e, input logic [3:0] a);
    reset   = r;
    en      = e;
    address = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_valid = 1'b0;
    exp_out   = 8'h00;
    tbl = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78,
            8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};
    reset   = 1'b1;
    en      = 1'b1;
    address = 4'h5;

    // Reset held two edges with a read requested
    drive(1'b1, 1'b1, 4'h5);
    check("reset_edge1", dout, 8'h00);
    drive(1'b1, 1'b1, 4'h5);
    check("reset_edge2", dout, 8'h00);
    // Release with enable off
    drive(1'b0, 1'b0, 4'h5);
    check("reset_release", dout, 8'h00);

    // Enable off while address moves
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, i[3:0]);
      check("enable_off", dout, 8'h00);
    end

    // Single reads on successive edges
    drive(1'b0, 1'b1, 4'h1);
    check("read_1", dout, 8'h1E);
    drive(1'b0, 1'b1, 4'hF);
    check("read_F", dout, 8'hF0);
    drive(1'b0, 1'b1, 4'hA);
    check("read_A", dout, 8'hA5);

    // Hold with enable low and a different / unknown address
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 4'h3);
      check("hold", dout, 8'hA5);
    end
    drive(1'b0, 1'b0, 4'bxxxx);
    check("hold_x_addr", dout, 8'hA5);

    // Reset priority over a simultaneous read
    drive(1'b0, 1'b1, 4'hF);
    check("pre_reset_F", dout, 8'hF0);
    drive(1'b1, 1'b1, 4'h2);
    check("reset_priority", dout, 8'h00);
    drive(1'b0, 1'b1, 4'h2);
    check("read_after_reset", dout, 8'h2D);

    // Full sweep against the literal table (also pins the model formula)
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, i[3:0]);
      check("sweep", dout, tbl[i]);
      check("model_pin", {i[3:0], ~i[3:0]}, tbl[i]);
    end

    // Randomized traffic, checked by the compare process
    for (int n = 0; n < 2000; n++) begin
      logic r;
      logic e;
      logic [3:0] a;
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      a = 4'($urandom_range(0, 15));
      if ((!e || r) && ($urandom_range(0, 1) == 1)) begin
        a = 4'bxxxx;
      end
      drive(r, e, a);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
